pe_input_sequencer: RTL

Transmit-side driver for a single PE's input bundle: a, b, d, control, id, last and valid.
- Accepts a tile command plus a ready/valid row-data stream and converts them into the valid-qualified, non-backpressured PE input stream.
- Stamps every beat with the tile's id, dataflow and shift, and asserts last on the final row.
- Alternates propagate between consecutive tiles.
- Sits between the scratchpad read path and the PE / mesh input edge.

---
 rtl/pe_input_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/pe_input_sequencer.sv
// ---------------------------------------------------------------------------
// pe_input_sequencer
//
// Purpose:
//   Transmit-side driver for one PE input bundle. It takes a tile command and
//   a ready/valid stream of row data. It turns them into the valid-qualified,
//   non-backpressured PE input stream. Each beat is stamped with the tile id,
//   dataflow and shift. The final row of a tile carries last. Propagate
//   alternates between consecutive tiles. A command arriving on the final beat
//   of a tile is accepted in that same cycle, so tiles stream with no bubble.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    tile command handshake
//   cmd_id, cmd_rows,        tile id, row count (0 encodes ROWS_MAX),
//   cmd_dataflow, cmd_shift  dataflow select, output shift
//   data_valid / data_ready  row beat handshake
//   data_a, data_b, data_d   row operands
//   pe_in_*                  registered PE input bundle
//   busy                     high while a tile is streaming
//   tiles_done               completed-tile counter, wraps 255 -> 0
//
// States:
//   state  | meaning
//   IDLE   | waiting for a tile command; row data not accepted
//   STREAM | tile active; every data beat is forwarded to the PE
// ---------------------------------------------------------------------------
module pe_input_sequencer #(
  parameter int A_W      = 8,
  parameter int BD_W     = 20,
  parameter int ID_W     = 3,
  parameter int SHIFT_W  = 5,
  parameter int ROWS_MAX = 16,
  parameter int CNT_W    = $clog2(ROWS_MAX)
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic [CNT_W-1:0]   cmd_rows,
  input  logic               cmd_dataflow,
  input  logic [SHIFT_W-1:0] cmd_shift,

  input  logic               data_valid,
  output logic               data_ready,
  input  logic [A_W-1:0]     data_a,
  input  logic [BD_W-1:0]    data_b,
  input  logic [BD_W-1:0]    data_d,

  output logic               pe_in_valid,
  output logic [A_W-1:0]     pe_in_a,
  output logic [BD_W-1:0]    pe_in_b,
  output logic [BD_W-1:0]    pe_in_d,
  output logic               pe_in_control_dataflow,
  output logic               pe_in_control_propagate,
  output logic [SHIFT_W-1:0] pe_in_control_shift,
  output logic [ID_W-1:0]    pe_in_id,
  output logic               pe_in_last,

  output logic               busy,
  output logic [7:0]         tiles_done
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Tile context latched on command acceptance.
  logic [CNT_W-1:0]   row_cnt_q;
  logic [CNT_W-1:0]   last_idx_q;
  logic [ID_W-1:0]    id_q;
  logic               dataflow_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               cur_prop_q;
  logic               prop_reg_q;
  logic [7:0]         tiles_done_q;

  logic               at_last;
  logic               cmd_fire;
  logic               data_fire;
  logic               tile_end;
  logic [CNT_W-1:0]   cmd_last_idx;

  // The row count is held as the index of the final row. A count of 0 wraps
  // to ROWS_MAX-1 here, so a full-size tile needs no extra counter bit and
  // row_cnt never wraps before the final row.
  assign cmd_last_idx = cmd_rows - CNT_W'(1);

  assign at_last   = (row_cnt_q == last_idx_q);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign data_fire = data_valid & data_ready;
  assign tile_end  = data_fire & at_last;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        // A command taken on the final beat keeps the FSM streaming.
        if (tile_end && !cmd_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so that every output reads 0.
        cmd_ready = !rst;
      end
      STREAM: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        // The next tile may be accepted only on the beat that ends this one.
        cmd_ready  = data_valid & at_last;
      end
      default: begin
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Tile context, row counter, propagate and tile counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q    <= '0;
      last_idx_q   <= '0;
      id_q         <= '0;
      dataflow_q   <= 1'b0;
      shift_q      <= '0;
      cur_prop_q   <= 1'b0;
      prop_reg_q   <= 1'b0;
      tiles_done_q <= '0;
    end else begin
      if (tile_end) begin
        prop_reg_q   <= ~prop_reg_q;
        tiles_done_q <= tiles_done_q + 8'd1;
      end

      if (cmd_fire) begin
        id_q       <= cmd_id;
        dataflow_q <= cmd_dataflow;
        shift_q    <= cmd_shift;
        last_idx_q <= cmd_last_idx;
        row_cnt_q  <= '0;
        // On a back-to-back accept the toggle above has not landed yet, so
        // the new tile takes the toggled value directly.
        cur_prop_q <= tile_end ? ~prop_reg_q : prop_reg_q;
      end else if (tile_end) begin
        row_cnt_q  <= '0;
      end else if (data_fire) begin
        row_cnt_q  <= row_cnt_q + CNT_W'(1);
      end
    end
  end

  assign tiles_done = tiles_done_q;

  // -------------------------------------------------------------------------
  // Registered PE input bundle. Payload and sideband hold between beats;
  // only pe_in_valid qualifies them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_in_valid             <= 1'b0;
      pe_in_a                 <= '0;
      pe_in_b                 <= '0;
      pe_in_d                 <= '0;
      pe_in_control_dataflow  <= 1'b0;
      pe_in_control_propagate <= 1'b0;
      pe_in_control_shift     <= '0;
      pe_in_id                <= '0;
      pe_in_last              <= 1'b0;
    end else begin
      pe_in_valid <= data_fire;
      if (data_fire) begin
        pe_in_a                 <= data_a;
        pe_in_b                 <= data_b;
        pe_in_d                 <= data_d;
        pe_in_control_dataflow  <= dataflow_q;
        pe_in_control_propagate <= cur_prop_q;
        pe_in_control_shift     <= shift_q;
        pe_in_id                <= id_q;
        pe_in_last              <= at_last;
      end
    end
  end

endmodule
